// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed scan controller for an 8-digit common-anode seven-segment
// display. Display data is double buffered: a load strobe captures the value,
// decimal-point mask and digit-enable mask into a staging copy, and the
// staging copy moves into the displayed (shadow) copy only at the end of a
// frame, so a frame never shows a mix of old and new data.
//
// Every digit slot is a BLANK phase (all anodes off, BLANK_CYC cycles)
// followed by a DRIVE phase (one anode on, REFRESH_DIV cycles). Disabled
// digits keep the full slot length but stay dark.
//
// Parameters
//   REFRESH_DIV  clock cycles each digit is driven (>= 1)
//   BLANK_CYC    clock cycles all anodes are off before each digit (>= 1)
//
// Ports
//   clock       system clock, rising-edge active
//   reset       asynchronous, active-low reset
//   load        one-cycle strobe, captures value/dp_mask/digit_en into staging
//   value       32-bit hex data, nibble k is shown on digit k
//   dp_mask     bit k lights the decimal point of digit k
//   digit_en    bit k = 0 keeps digit k dark
//   pending     staged data waiting for the next frame commit
//   frame_done  one-cycle pulse at the start of the BLANK after digit 7
//   Anode       active-low digit select, at most one bit low
//   Cathode     active-low segments, bit 7 = DP, bits 6:0 = g..a
//
// Build option
//   SEG_SCAN_LZB_EN  when defined, leading zeros (from digit 7 down to
//                    digit 1) are blanked together with their DP.
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] value,
    input  logic [7:0]  dp_mask,
    input  logic [7:0]  digit_en,
    output logic        pending,
    output logic        frame_done,
    output logic [7:0]  Anode,
    output logic [7:0]  Cathode
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // Active-low segment pattern for one hex nibble, DP bit (7) off.
    function automatic logic [7:0] seg_code(input logic [3:0] nib);
        logic [7:0] code;
        code = 8'hFF;
        case (nib)
            4'h0: code = 8'hC0;
            4'h1: code = 8'hF9;
            4'h2: code = 8'hA4;
            4'h3: code = 8'hB0;
            4'h4: code = 8'h99;
            4'h5: code = 8'h92;
            4'h6: code = 8'h82;
            4'h7: code = 8'hF8;
            4'h8: code = 8'h80;
            4'h9: code = 8'h98;
            4'hA: code = 8'h88;
            4'hB: code = 8'h83;
            4'hC: code = 8'hC6;
            4'hD: code = 8'hA1;
            4'hE: code = 8'h86;
            4'hF: code = 8'h8E;
        endcase
        return code;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t           state_q,     state_d;
    logic [2:0]       idx_q,       idx_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             run_q,       run_d;

    logic [31:0]      stg_value_q, stg_value_d;
    logic [7:0]       stg_dp_q,    stg_dp_d;
    logic [7:0]       stg_en_q,    stg_en_d;

    logic [31:0]      shd_value_q, shd_value_d;
    logic [7:0]       shd_dp_q,    shd_dp_d;
    logic [7:0]       shd_en_q,    shd_en_d;

    logic             pending_q,   pending_d;
    logic             frame_dn_q,  frame_dn_d;
    logic [7:0]       anode_q,     anode_d;
    logic [7:0]       cathode_q,   cathode_d;

    logic [7:0]       lzb_mask;
    logic             digit_on;
    logic [3:0]       cur_nib;

    // ------------------------------------------------------------------------
    // Leading-zero blanking mask, derived from the shadow copy only, so it
    // can change only at a frame commit.
    // ------------------------------------------------------------------------
`ifdef SEG_SCAN_LZB_EN
    always_comb begin
        logic lead;
        lead     = 1'b1;
        lzb_mask = 8'h00;
        // Digit 0 is never a leading zero; the scan stops at the first
        // non-zero nibble whether or not that digit is enabled.
        for (int k = 7; k >= 1; k--) begin
            if (shd_value_q[4*k +: 4] != 4'h0) begin
                lead = 1'b0;
            end
            lzb_mask[k] = lead;
        end
    end
`else
    assign lzb_mask = 8'h00;
`endif

    assign cur_nib  = shd_value_q[{idx_q, 2'b00} +: 4];
    assign digit_on = shd_en_q[idx_q] & ~lzb_mask[idx_q];

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        logic frame_end;

        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        run_d       = 1'b1;
        stg_value_d = stg_value_q;
        stg_dp_d    = stg_dp_q;
        stg_en_d    = stg_en_q;
        shd_value_d = shd_value_q;
        shd_dp_d    = shd_dp_q;
        shd_en_d    = shd_en_q;
        pending_d   = pending_q;
        frame_dn_d  = 1'b0;
        frame_end   = 1'b0;

        // The reset state is held until the first edge after release; that
        // edge opens the first BLANK cycle, so the first slot has the same
        // length as every later one.
        if (run_q) begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == DRIVE_LAST) begin
                        state_d   = ST_BLANK;
                        cnt_d     = '0;
                        idx_d     = idx_q + 3'd1;
                        frame_end = (idx_q == 3'd7);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                end
            endcase
        end

        frame_dn_d = frame_end;

        // Commit reads the staging registers as they were before this edge,
        // so a load arriving on the commit edge waits for the next frame.
        if (frame_end && pending_q) begin
            shd_value_d = stg_value_q;
            shd_dp_d    = stg_dp_q;
            shd_en_d    = stg_en_q;
            pending_d   = 1'b0;
        end

        if (load) begin
            stg_value_d = value;
            stg_dp_d    = dp_mask;
            stg_en_d    = digit_en;
            pending_d   = 1'b1;
        end

        // Registered pin drive: during DRIVE idx is stable and the shadow
        // copy cannot change (commit only happens when leaving DRIVE).
        anode_d   = 8'hFF;
        cathode_d = 8'hFF;
        if (state_d == ST_DRIVE && digit_on) begin
            anode_d   = ~(8'h01 << idx_q);
            cathode_d = seg_code(cur_nib) & ~{shd_dp_q[idx_q], 7'b000_0000};
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // NOTE: staging and shadow are ordinary registers, not a memory array, so
    // they take the asynchronous reset like the rest; a reset discards any
    // staged frame and leaves every digit disabled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_BLANK;
            idx_q       <= 3'd0;
            cnt_q       <= '0;
            run_q       <= 1'b0;
            stg_value_q <= 32'h0;
            stg_dp_q    <= 8'h00;
            stg_en_q    <= 8'h00;
            shd_value_q <= 32'h0;
            shd_dp_q    <= 8'h00;
            shd_en_q    <= 8'h00;
            pending_q   <= 1'b0;
            frame_dn_q  <= 1'b0;
            anode_q     <= 8'hFF;
            cathode_q   <= 8'hFF;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            run_q       <= run_d;
            stg_value_q <= stg_value_d;
            stg_dp_q    <= stg_dp_d;
            stg_en_q    <= stg_en_d;
            shd_value_q <= shd_value_d;
            shd_dp_q    <= shd_dp_d;
            shd_en_q    <= shd_en_d;
            pending_q   <= pending_d;
            frame_dn_q  <= frame_dn_d;
            anode_q     <= anode_d;
            cathode_q   <= cathode_d;
        end
    end

    assign pending    = pending_q;
    assign frame_done = frame_dn_q;
    assign Anode      = anode_q;
    assign Cathode    = cathode_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Bench for seg_scan_ctrl with REFRESH_DIV = 4, BLANK_CYC = 2 (slot = 6 cycles,
// frame = 48 cycles). Outputs are sampled on the falling edge. A table of
// display records is loaded one by one; each load pushes the eight expected
// (Anode, Cathode) digit slots onto a scoreboard queue, and the frame after the
// commit pops and compares them. Hand-written sequences cover reset release,
// mid-frame reset, last-load-wins and a load on the commit edge.
// Expected leading-zero behaviour follows SEG_SCAN_LZB_EN.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int RDIV = 4;
    localparam int BCYC = 2;
    localparam int SLOT = RDIV + BCYC;
    localparam int FRAME = 8 * SLOT;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [31:0] value = 32'h0;
    logic [7:0]  dp_mask = 8'h00;
    logic [7:0]  digit_en = 8'h00;
    logic        pending;
    logic        frame_done;
    logic [7:0]  Anode;
    logic [7:0]  Cathode;

    seg_scan_ctrl #(
        .REFRESH_DIV (RDIV),
        .BLANK_CYC   (BCYC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .value      (value),
        .dp_mask    (dp_mask),
        .digit_en   (digit_en),
        .pending    (pending),
        .frame_done (frame_done),
        .Anode      (Anode),
        .Cathode    (Cathode)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] value;
        logic [7:0]  dp;
        logic [7:0]  en;
        logic [63:0] exp_cath;   // byte k = expected Cathode of digit k
    } vec_t;

    typedef struct packed {
        logic [7:0] anode;
        logic [7:0] cathode;
    } slot_t;

    slot_t sb_q[$];
    vec_t  vecs[5];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic push_frame(input vec_t v);
        slot_t e;
        for (int k = 0; k < 8; k++) begin
            e.cathode = v.exp_cath[8*k +: 8];
            e.anode   = (e.cathode == 8'hFF) ? 8'hFF : ~(8'h01 << k);
            sb_q.push_back(e);
        end
    endtask

    // Drives a one-cycle load starting at the current falling edge.
    task automatic do_load(input vec_t v, input bit push);
        value    = v.value;
        dp_mask  = v.dp;
        digit_en = v.en;
        load     = 1'b1;
        if (push) push_frame(v);
        step();
        load = 1'b0;
        check({"pending_after_load_", v.name}, {31'h0, pending}, 32'h1);
    endtask

    task automatic wait_fd(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (frame_done !== 1'b1 && n < 2 * FRAME);
        check({"frame_done_reached_", name}, {31'h0, frame_done}, 32'h1);
    endtask

    // Called on a frame_done sample (first BLANK cycle of digit 0). Walks the
    // whole frame and ends on the next frame_done sample.
    task automatic check_frame(input string name, input bit exp_pend);
        slot_t cur;
        slot_t exp;
        int    ph;
        cur = '{anode: 8'hFF, cathode: 8'hFF};
        for (int s = 1; s <= FRAME; s++) begin
            step();
            ph = s % SLOT;
            if (s < FRAME && ph == BCYC) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL scoreboard_empty_%s: got 0 entries expected 1 at %0t", name, $time);
                end else begin
                    cur = sb_q.pop_front();
                end
            end
            exp = (s < FRAME && ph >= BCYC) ? cur : '{anode: 8'hFF, cathode: 8'hFF};
            check({"frame_", name},
                  {14'h0, frame_done, pending, Anode, Cathode},
                  {14'h0, (s == FRAME), (s < FRAME) ? exp_pend : 1'b0, exp.anode, exp.cathode});
        end
    endtask

    // Called on the falling edge where reset is released; the shadow copy
    // is empty, so the first frame is dark and frame_done comes after one
    // lead-in edge plus a full frame.
    task automatic check_startup(input string name);
        for (int s = 1; s <= FRAME + 1; s++) begin
            step();
            check({"startup_", name},
                  {22'h0, frame_done, pending, Anode, Cathode},
                  {22'h0, (s == FRAME + 1), 1'b0, 8'hFF, 8'hFF});
        end
    endtask

    always @(negedge clock) begin
        if (reset) check("anode_onehot", {31'h0, ($countones(~Anode) <= 1)}, 32'h1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{name: "hex12AF", value: 32'h0000_12AF, dp: 8'h02, en: 8'h0F,
                    exp_cath: 64'hFFFF_FFFF_F9A4_088E};
        vecs[1] = '{name: "sparse_en", value: 32'hFEDC_BA98, dp: 8'h00, en: 8'hA5,
                    exp_cath: 64'h8EFF_A1FF_FF88_FF80};
`ifdef SEG_SCAN_LZB_EN
        vecs[2] = '{name: "lzb_0070", value: 32'h0000_0070, dp: 8'h00, en: 8'hFF,
                    exp_cath: 64'hFFFF_FFFF_FFFF_F8C0};
        vecs[3] = '{name: "lzb_zero", value: 32'h0000_0000, dp: 8'hFF, en: 8'hFF,
                    exp_cath: 64'hFFFF_FFFF_FFFF_FF40};
`else
        vecs[2] = '{name: "lzb_0070", value: 32'h0000_0070, dp: 8'h00, en: 8'hFF,
                    exp_cath: 64'hC0C0_C0C0_C0C0_F8C0};
        vecs[3] = '{name: "lzb_zero", value: 32'h0000_0000, dp: 8'hFF, en: 8'hFF,
                    exp_cath: 64'h4040_4040_4040_4040};
`endif
        vecs[4] = '{name: "all_76543210", value: 32'h7654_3210, dp: 8'h81, en: 8'hFF,
                    exp_cath: 64'h7882_9299_B0A4_F940};

        // Reset state, then release and check the dark first frame timing.
        step();
        step();
        check("reset_state", {22'h0, frame_done, pending, Anode, Cathode}, {22'h0, 1'b0, 1'b0, 8'hFF, 8'hFF});
        reset = 1'b1;
        check_startup("power_on");

        // Table: load mid-frame, commit at frame_done, check the next frame.
        for (int i = 0; i < 5; i++) begin
            repeat (10) step();
            do_load(vecs[i], 1'b1);
            wait_fd(vecs[i].name);
            check({"pending_cleared_", vecs[i].name}, {31'h0, pending}, 32'h0);
            check_frame(vecs[i].name, 1'b0);
        end

        // Mid-frame reset during the digit-5 DRIVE phase, with data staged.
        repeat (10) step();
        do_load(vecs[0], 1'b0);
        repeat (3 * 7 + 1) step();
        check("pre_reset_digit5", {16'h0, Anode, Cathode}, {16'h0, 8'hDF, 8'h92});
        reset = 1'b0;
        #1;
        check("midframe_reset", {22'h0, frame_done, pending, Anode, Cathode}, {22'h0, 1'b0, 1'b0, 8'hFF, 8'hFF});
        step();
        step();
        reset = 1'b1;
        check_startup("after_midframe_reset");

        // Last load wins: two loads in one frame, only the second is shown.
        repeat (5) step();
        do_load(vecs[4], 1'b0);
        repeat (5) step();
        do_load(vecs[0], 1'b1);
        wait_fd("last_load_wins");
        check_frame("last_load_wins", 1'b0);

        // Load on the commit edge: the earlier staging commits, the new load
        // stays pending and commits one frame later.
        repeat (10) step();
        do_load(vecs[4], 1'b1);
        repeat (FRAME - 12) step();
        value    = vecs[1].value;
        dp_mask  = vecs[1].dp;
        digit_en = vecs[1].en;
        load     = 1'b1;
        push_frame(vecs[1]);
        step();
        load = 1'b0;
        check("collision_edge", {30'h0, frame_done, pending}, {30'h0, 1'b1, 1'b1});
        check_frame("collision_first", 1'b1);
        check_frame("collision_second", 1'b0);

        check("scoreboard_drained", sb_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
